// File: rtl/ieee754_acc_seq.sv
// Accumulates a length-tagged stream of IEEE 754 singles through an external
// combinational adder. Optional saturation on overflow: define IEEE754_ACC_SAT_EN.
module ieee754_acc_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_s,
  input  logic             add_ovf,
  input  logic             add_unf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic             out_ovf,
  output logic             out_unf,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state_reg, state_next;
  logic [31:0]      acc_reg;
  logic [CNT_W-1:0] count_reg;
  logic             ovf_sticky_reg, unf_sticky_reg;
  logic [31:0]      out_sum_reg;
  logic             out_ovf_reg, out_unf_reg, out_valid_reg;

  logic             accept;
  logic             last_accept;
  logic [31:0]      acc_upd;
  logic             ovf_upd, unf_upd;

  // Value the accumulator takes on an accept.
`ifdef IEEE754_ACC_SAT_EN
  assign acc_upd = add_ovf ? (add_s[31] ? 32'hFF7FFFFF : 32'h7F7FFFFF) : add_s;
`else
  assign acc_upd = add_s;
`endif

  assign ovf_upd     = ovf_sticky_reg | add_ovf;
  assign unf_upd     = unf_sticky_reg | add_unf;
  assign last_accept = accept && (count_reg == {{(CNT_W-1){1'b0}}, 1'b1});

  assign add_a     = acc_reg;
  assign add_b     = in_data;
  assign out_valid = out_valid_reg;
  assign out_sum   = out_sum_reg;
  assign out_ovf   = out_ovf_reg;
  assign out_unf   = out_unf_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    accept     = 1'b0;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && (count_reg == {{(CNT_W-1){1'b0}}, 1'b1})) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: accumulator, element counter, sticky flags and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg        <= 32'h0;
      count_reg      <= '0;
      ovf_sticky_reg <= 1'b0;
      unf_sticky_reg <= 1'b0;
      out_sum_reg    <= 32'h0;
      out_ovf_reg    <= 1'b0;
      out_unf_reg    <= 1'b0;
      out_valid_reg  <= 1'b0;
    end else begin
      out_valid_reg <= (state_next == DONE);
      if ((state_reg == IDLE) && start) begin
        acc_reg        <= 32'h0;
        count_reg      <= len;
        ovf_sticky_reg <= 1'b0;
        unf_sticky_reg <= 1'b0;
        if (len == '0) begin
          out_sum_reg <= 32'h0;
          out_ovf_reg <= 1'b0;
          out_unf_reg <= 1'b0;
        end
      end
      if (accept) begin
        acc_reg        <= acc_upd;
        ovf_sticky_reg <= ovf_upd;
        unf_sticky_reg <= unf_upd;
        count_reg      <= count_reg - 1'b1;
      end
      // The final element's contribution goes straight into the result.
      if (last_accept) begin
        out_sum_reg <= acc_upd;
        out_ovf_reg <= ovf_upd;
        out_unf_reg <= unf_upd;
      end
    end
  end

endmodule

// File: tb/tb_ieee754_acc_seq.sv
// Self-checking bench for ieee754_acc_seq with a behavioural single-precision
// adder in the environment; honours IEEE754_ACC_SAT_EN like the design.
module tb_ieee754_acc_seq;
  localparam int CNT_W = 8;
`ifdef IEEE754_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic [31:0]      in_data = 32'h0;
  logic             in_ready;
  logic [31:0]      add_a, add_b, add_s;
  logic             add_ovf, add_unf;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_sum;
  logic             out_ovf, out_unf, busy;

  int errors = 0;
  int checks = 0;
  logic [31:0] elems[$];

  always #5 clk = ~clk;

  ieee754_acc_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .add_a(add_a), .add_b(add_b), .add_s(add_s), .add_ovf(add_ovf), .add_unf(add_unf),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_ovf(out_ovf), .out_unf(out_unf), .busy(busy)
  );

  // Single -> double (subnormal inputs flushed to signed zero).
  function automatic real s2r(input logic [31:0] f);
    logic [10:0] ed;
    if (f[30:23] == 8'h00) return $bitstoreal({f[31], 63'b0});
    if (f[30:23] == 8'hFF) ed = 11'h7FF;
    else ed = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], ed, f[22:0], 29'b0});
  endfunction

  // Double -> single by truncation; returns {sum, ovf, unf}.
  function automatic logic [33:0] r2s(input real r);
    logic [63:0] d;
    int es;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'b0, 2'b00};
    es = int'(d[62:52]) - 896;
    if (es >= 255) return {d[63], 8'hFF, 23'b0, 2'b10};
    if (es <= 0) return {d[63], 31'b0, 2'b01};
    return {d[63], es[7:0], d[51:29], 2'b00};
  endfunction

  function automatic logic [33:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2s(s2r(a) + s2r(b));
  endfunction

  assign {add_s, add_ovf, add_unf} = fadd(add_a, add_b);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_elem(input int emin, input int emax);
    logic [31:0] f;
    f = $urandom;
    f[30:23] = 8'($urandom_range(emax, emin));
    return f;
  endfunction

  // gap_mode: 0 back-to-back, 1 one idle cycle before every element, 2 random 0..2 idles.
  task automatic run_vec(input string name, input int gap_mode, input int hold);
    logic [33:0] r;
    logic [31:0] acc, es;
    logic eo, eu;
    int n, gaps;
    n = elems.size();
    acc = 32'h0; eo = 1'b0; eu = 1'b0;
    foreach (elems[i]) begin
      r = fadd(acc, elems[i]);
      eo |= r[1];
      eu |= r[0];
      acc = (SAT && r[1]) ? (r[33] ? 32'hFF7FFFFF : 32'h7F7FFFFF) : r[33:2];
    end
    es = acc;
    chk({name, ".idle_busy"}, {31'b0, busy}, 32'd0);
    start = 1'b1; len = n[CNT_W-1:0];
    tick();
    start = 1'b0;
    if (n == 0) chk({name, ".len0_in_ready"}, {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < n; i++) begin
      gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(2, 0)) : 0;
      for (int g = 0; g < gaps; g++) begin
        in_valid = 1'b0; in_data = $urandom;
        tick();
        chk({name, ".gap_no_out"}, {31'b0, out_valid}, 32'd0);
      end
      in_valid = 1'b1; in_data = elems[i];
      chk({name, ".in_ready"}, {31'b0, in_ready}, 32'd1);
      chk({name, ".pre_out_valid"}, {31'b0, out_valid}, 32'd0);
      tick();
      in_valid = 1'b0;
    end
    chk({name, ".out_valid"}, {31'b0, out_valid}, 32'd1);
    chk({name, ".out_sum"}, out_sum, es);
    chk({name, ".out_ovf"}, {31'b0, out_ovf}, {31'b0, eo});
    chk({name, ".out_unf"}, {31'b0, out_unf}, {31'b0, eu});
    chk({name, ".done_in_ready"}, {31'b0, in_ready}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0; start = 1'(h % 2); len = 8'd3;
      tick();
      chk({name, ".hold_valid"}, {31'b0, out_valid}, 32'd1);
      chk({name, ".hold_sum"}, out_sum, es);
    end
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, ".drain_valid"}, {31'b0, out_valid}, 32'd0);
    chk({name, ".drain_busy"}, {31'b0, busy}, 32'd0);
    chk({name, ".retain_sum"}, out_sum, es);
    $display("vector %s len=%0d sum=%h ovf=%0b unf=%0b", name, n, es, eo, eu);
  endtask

  initial begin
    logic [31:0] d;
    #1;
    chk("rst.busy", {31'b0, busy}, 32'd0);
    chk("rst.in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst.out_sum", out_sum, 32'd0);
    chk("rst.add_a", add_a, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    d = $urandom; in_data = d; #1;
    chk("idle.add_b", add_b, d);

    elems = '{32'h3F800000, 32'h40000000, 32'h40400000};
    run_vec("sum123", 0, 0);
    chk("sum123.const", out_sum, 32'h40C00000);
    elems = '{32'hC0000000, 32'h40000000};
    run_vec("cancel", 1, 0);
    chk("cancel.const", out_sum, 32'h00000000);
    elems = {};
    run_vec("len0", 0, 0);
    elems = '{32'h7F7FFFFF, 32'h7F7FFFFF};
    run_vec("ovf", 0, 5);
    chk("ovf.flag", {31'b0, out_ovf}, 32'd1);
    chk("ovf.sum", out_sum, SAT ? 32'h7F7FFFFF : 32'h7F800000);
    elems = '{32'h00800001, 32'h80800000};
    run_vec("unf", 0, 0);

    for (int v = 0; v < 6; v++) begin
      elems = {};
      for (int k = 0; k < int'($urandom_range(8, 1)); k++) elems.push_back(rand_elem(110, 140));
      run_vec($sformatf("rand%0d", v), 2, int'($urandom_range(2, 0)));
    end
    elems = {};
    for (int k = 0; k < 255; k++) elems.push_back(rand_elem(120, 130));
    run_vec("len255", 0, 0);

    // Reset after one accepted element discards the partial sum.
    start = 1'b1; len = 8'd3;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 32'h40000000;
    tick();
    in_valid = 1'b0;
    chk("mid.acc_loaded", add_a, 32'h40000000);
    rst = 1'b1; #1;
    chk("mid.rst_busy", {31'b0, busy}, 32'd0);
    chk("mid.rst_acc", add_a, 32'd0);
    chk("mid.rst_out_valid", {31'b0, out_valid}, 32'd0);
    $display("reset mid-vector busy=%0b acc=%h", busy, add_a);
    tick();
    rst = 1'b0;
    tick();
    elems = '{32'h3F800000};
    run_vec("after_rst", 0, 0);
    chk("after_rst.const", out_sum, 32'h3F800000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
